chr_vram_sched: RTL

Scheduler for the single-port character/font VRAM in the character generator. It sits between the NTSC timing generator and the VRAM. During active display lines it issues a fixed fetch pattern per character cell: the code read, then the font-row read. It hands every remaining RAM cycle, and all blanking time, to a host write/read port through a REQ/ACK handshake. The block emits one font byte per cell to the downstream pixel serializer.

---
 rtl/chr_gen_pkg.sv | 29 ++
 rtl/chr_cell_ctr.sv | 51 +++++
 rtl/chr_vram_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/chr_gen_pkg.sv
// Shared constants, state encoding and font address helper for the
// character generator VRAM scheduler.
package chr_gen_pkg;

    localparam int P_ADR_W = 12;
    localparam int P_DAT_W = 8;
    localparam int P_COLS  = 32;
    localparam int P_ROWS  = 24;
    localparam int COL_W   = $clog2(P_COLS);

    localparam logic [P_ADR_W-1:0] P_FONT_BASE = 12'h800;
    localparam logic [7:0]         LINE_END    = 8'(8 * P_ROWS);

    localparam logic [2:0] SLOT_CODE = 3'd0;
    localparam logic [2:0] SLOT_FONT = 3'd2;
    localparam logic [2:0] SLOT_LOAD = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FETCH = 2'd2
    } state_e;

    function automatic logic [P_ADR_W-1:0] font_adr(input logic [P_DAT_W-1:0] code,
                                                    input logic [2:0]         row);
        font_adr = P_FONT_BASE + P_ADR_W'({code, row});
    endfunction

endpackage

// File: rtl/chr_cell_ctr.sv
// Slot/column/line counters of a fetch run, with next-slot lookahead so the
// top level can decide the RAM port one cycle ahead of it being driven.
module chr_cell_ctr
    import chr_gen_pkg::*;
(
    input  logic             CK,
    input  logic             AR,
    input  logic             EE,
    input  logic             i_start,
    input  logic             i_adv,
    input  logic             i_vstart,
    output logic [2:0]       o_slot,
    output logic [2:0]       o_nxt_slot,
    output logic [COL_W-1:0] o_nxt_col,
    output logic [7:0]       o_line,
    output logic             o_run_end,
    output logic             o_last_line
);

    logic [2:0]       r_slot;
    logic [COL_W-1:0] r_col;
    logic [7:0]       r_line;
    logic             w_cell_end;

    assign w_cell_end  = (r_slot == SLOT_LOAD);
    assign o_run_end   = w_cell_end && (r_col == COL_W'(P_COLS - 1));
    assign o_last_line = (r_line == (LINE_END - 8'd1));
    assign o_nxt_slot  = i_start ? SLOT_CODE : (r_slot + 3'd1);
    assign o_nxt_col   = i_start ? {COL_W{1'b0}} : (r_col + COL_W'(w_cell_end));
    assign o_slot      = r_slot;
    assign o_line      = r_line;

    always_ff @(posedge CK or posedge AR) begin
        if (AR) begin
            r_slot <= 3'd0;
            r_col  <= {COL_W{1'b0}};
            r_line <= 8'd0;
        end else if (EE) begin
            if (i_start || i_adv) begin
                r_slot <= o_nxt_slot;
                r_col  <= o_nxt_col;
            end
            if (i_vstart) begin
                r_line <= 8'd0;
            end else if (i_adv && o_run_end) begin
                r_line <= r_line + 8'd1;
            end
        end
    end

endmodule

// File: rtl/chr_vram_sched.sv
// Single-port VRAM scheduler: fixed code/font fetch slots during active lines,
// every other RAM cycle granted to the host REQ/ACK port.
module chr_vram_sched
    import chr_gen_pkg::*;
(
    input  logic               CK,
    input  logic               AR,
    input  logic               EE,
    input  logic               H_START,
    input  logic               V_START,
    input  logic               HOST_REQ,
    input  logic               HOST_WE,
    input  logic [P_ADR_W-1:0] HOST_ADR,
    input  logic [P_DAT_W-1:0] HOST_WD,
    output logic               HOST_ACK,
    output logic [P_DAT_W-1:0] HOST_RD,
    output logic               HOST_RVLD,
    output logic [P_ADR_W-1:0] RAM_ADR,
    output logic               RAM_WE,
    output logic [P_DAT_W-1:0] RAM_WD,
    input  logic [P_DAT_W-1:0] RAM_RD,
    output logic [P_DAT_W-1:0] PIX_BITS,
    output logic               PIX_LOAD
);

    state_e             r_state;
    logic [P_DAT_W-1:0] r_font;

    logic               w_in_fetch;
    logic               w_start;
    logic               w_adv;
    logic               w_nxt_disp;
    logic               w_disp_slot;
    logic [2:0]         w_slot;
    logic [2:0]         w_nxt_slot;
    logic [COL_W-1:0]   w_nxt_col;
    logic [7:0]         w_line;
    logic [7:0]         w_line_cur;
    logic               w_run_end;
    logic               w_last_line;

    // V_START coincident with H_START starts line 0 immediately
    assign w_in_fetch  = (r_state == ST_FETCH);
    assign w_start     = H_START && (V_START || (r_state == ST_ARMED));
    assign w_adv       = w_in_fetch && !V_START;
    assign w_nxt_disp  = w_start || (w_adv && !w_run_end);
    assign w_disp_slot = w_nxt_disp && ((w_nxt_slot == SLOT_CODE) || (w_nxt_slot == SLOT_FONT));
    assign w_line_cur  = V_START ? 8'd0 : w_line;

    chr_cell_ctr u_ctr (
        .CK          (CK),
        .AR          (AR),
        .EE          (EE),
        .i_start     (w_start),
        .i_adv       (w_adv),
        .i_vstart    (V_START),
        .o_slot      (w_slot),
        .o_nxt_slot  (w_nxt_slot),
        .o_nxt_col   (w_nxt_col),
        .o_line      (w_line),
        .o_run_end   (w_run_end),
        .o_last_line (w_last_line)
    );

    always_ff @(posedge CK or posedge AR) begin
        if (AR) begin
            r_state <= ST_IDLE;
        end else if (EE) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start)      r_state <= ST_FETCH;
                    else if (V_START) r_state <= ST_ARMED;
                    else              r_state <= ST_IDLE;
                end
                ST_ARMED: begin
                    if (w_start) r_state <= ST_FETCH;
                    else         r_state <= ST_ARMED;
                end
                ST_FETCH: begin
                    if (w_start)        r_state <= ST_FETCH;
                    else if (V_START)   r_state <= ST_ARMED;
                    else if (w_run_end) r_state <= w_last_line ? ST_IDLE : ST_ARMED;
                    else                r_state <= ST_FETCH;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Decisions target the next RAM cycle; in the slot before the font fetch
    // RAM_RD already carries the code read in the code slot.
    always_ff @(posedge CK or posedge AR) begin
        if (AR) begin
            RAM_ADR   <= {P_ADR_W{1'b0}};
            RAM_WE    <= 1'b0;
            RAM_WD    <= {P_DAT_W{1'b0}};
            HOST_ACK  <= 1'b0;
            HOST_RVLD <= 1'b0;
            PIX_BITS  <= {P_DAT_W{1'b0}};
            PIX_LOAD  <= 1'b0;
            r_font    <= {P_DAT_W{1'b0}};
        end else if (EE) begin
            RAM_WE    <= 1'b0;
            HOST_ACK  <= 1'b0;
            PIX_LOAD  <= 1'b0;
            HOST_RVLD <= HOST_ACK && !RAM_WE;
            if (w_disp_slot) begin
                if (w_nxt_slot == SLOT_CODE) RAM_ADR <= P_ADR_W'({w_line_cur[7:3], w_nxt_col});
                else                         RAM_ADR <= font_adr(RAM_RD, w_line_cur[2:0]);
            end else if (HOST_REQ) begin
                RAM_ADR  <= HOST_ADR;
                RAM_WE   <= HOST_WE;
                RAM_WD   <= HOST_WD;
                HOST_ACK <= 1'b1;
            end
            if (w_in_fetch && (w_slot == (SLOT_FONT + 3'd1))) begin
                r_font <= RAM_RD;
            end
            if (w_in_fetch && (w_slot == SLOT_LOAD)) begin
                PIX_BITS <= r_font;
                PIX_LOAD <= 1'b1;
            end
        end
    end

    // Read data is the RAM output in the cycle after the ACK, zero otherwise
    assign HOST_RD = HOST_RVLD ? RAM_RD : {P_DAT_W{1'b0}};

endmodule
